// File: rtl/op_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | op_sequencer_pkg - shared state, result-entry and width definitions  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package op_sequencer_pkg;

  // CMD/NUM mirror the most-significant-bit indices used by the engine
  localparam int CMD   = 3;
  localparam int NUM   = 15;
  localparam int CMD_W = CMD + 1;
  localparam int NUM_W = NUM + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PUSH  = 2'd3
  } state_e;

  typedef struct packed {
    logic             err;
    logic [NUM_W-1:0] data;
  } res_entry_t;

endpackage

`default_nettype wire

// File: rtl/op_sequencer_res_fifo.sv
// +----------------------------------------------------------------------+
// | res_fifo - first-word-fall-through result FIFO, typed entries        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module res_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  output logic push_ready_o,
  input  logic pop_i,
  output logic valid_o,
  output T     head_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             empty, full, do_pop, do_push;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == FULL_CNT);
  assign do_pop       = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ready_o = !full || do_pop;
  assign do_push      = push_i && push_ready_o;
  assign valid_o      = !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_comb begin
    head_o = '0;
    if (!empty) head_o = mem_q[rd_q];
  end

endmodule

`default_nettype wire

// File: rtl/op_sequencer.sv
// +----------------------------------------------------------------------+
// | op_sequencer - issues ops to an engine, collects results into a FIFO |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CMD_W-1:0] s_cmd,
  input  logic [NUM_W-1:0] s_a,
  input  logic [NUM_W-1:0] s_b,
  output logic             enable,
  output logic [CMD_W-1:0] cmd,
  output logic [NUM_W-1:0] in1,
  output logic [NUM_W-1:0] in2,
  input  logic [NUM_W-1:0] out,
  input  logic             valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [NUM_W-1:0] m_data,
  output logic             m_err,
  output logic [15:0]      ops_done,
  output logic [15:0]      timeouts,
  output logic             stray
);

  localparam int                TCNT_W   = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [NUM_W-1:0]  a_q, a_d;
  logic [NUM_W-1:0]  b_q, b_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  res_entry_t        res_q, res_d;
  logic [15:0]       ops_done_q, ops_done_d;
  logic [15:0]       timeouts_q, timeouts_d;
  logic              stray_q, stray_d;
  logic              fifo_push, fifo_push_ready;
  res_entry_t        fifo_head;

  // rdy_q keeps s_ready low until the first edge after reset releases
  assign s_ready = rdy_q && (state_q == ST_IDLE);
  assign enable  = (state_q == ST_ISSUE);
  assign cmd     = cmd_q;
  assign in1     = a_q;
  assign in2     = b_q;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    tcnt_d    = tcnt_q;
    res_d     = res_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          cmd_d   = s_cmd;
          a_d     = s_a;
          b_d     = s_b;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result landing on the last allowed cycle beats the timeout
        if (valid) begin
          res_d   = '{err: 1'b0, data: out};
          state_d = ST_PUSH;
        end else if (tcnt_q == TCNT_MAX) begin
          res_d   = '{err: 1'b1, data: '0};
          state_d = ST_PUSH;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_PUSH: begin
        if (fifo_push_ready) begin
          fifo_push = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ops_done_d = ops_done_q;
    timeouts_d = timeouts_q;
    stray_d    = stray_q;
    if (fifo_push) begin
      if (res_q.err) timeouts_d = timeouts_q + 16'd1;
      else           ops_done_d = ops_done_q + 16'd1;
    end
    if (valid && (state_q != ST_WAIT)) stray_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tcnt_q     <= '0;
      res_q      <= '0;
      ops_done_q <= '0;
      timeouts_q <= '0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tcnt_q     <= tcnt_d;
      res_q      <= res_d;
      ops_done_q <= ops_done_d;
      timeouts_q <= timeouts_d;
      stray_q    <= stray_d;
    end
  end

  res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (res_entry_t)
  ) u_res_fifo (
    .clk_i        (clk),
    .rst_i        (reset),
    .push_i       (fifo_push),
    .push_data_i  (res_q),
    .push_ready_o (fifo_push_ready),
    .pop_i        (m_ready),
    .valid_o      (m_valid),
    .head_o       (fifo_head)
  );

  assign m_data   = fifo_head.data;
  assign m_err    = fifo_head.err;
  assign ops_done = ops_done_q;
  assign timeouts = timeouts_q;
  assign stray    = stray_q;

endmodule

`default_nettype wire
